// File: rtl/branch_target_table_if.sv
// branch_target_table_if: lookup, write and invalidate signals of the branch target table
interface branch_target_table_if #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 8,
  parameter int BANK_W = 2
);
  logic [BANK_W-1:0] bank_sel;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_miss;
  logic              wr_en;
  logic [BANK_W-1:0] wr_bank;
  logic [IDX_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_rej;
  logic              clr_req;
  logic [BANK_W-1:0] clr_bank;
  logic              busy;
  modport master (
    output bank_sel, rd_en, rd_idx, wr_en, wr_bank, wr_idx, wr_addr, clr_req, clr_bank,
    input  rd_valid, rd_addr, rd_miss, wr_rej, busy
  );
  modport slave (
    input  bank_sel, rd_en, rd_idx, wr_en, wr_bank, wr_idx, wr_addr, clr_req, clr_bank,
    output rd_valid, rd_addr, rd_miss, wr_rej, busy
  );
endinterface

// File: rtl/branch_target_table.sv
// branch_target_table: banked, runtime-loaded PC target table with valid bits and sequenced bank invalidate
module branch_target_table #(
  parameter int IDX_W     = 4,
  parameter int ADDR_W    = 8,
  parameter int NUM_BANKS = 3,
  parameter int BANK_W    = 2
) (
  input logic                 CLK,
  input logic                 reset,
  branch_target_table_if.slave bus
);
  localparam int DEPTH = 2**IDX_W;
  localparam logic [BANK_W:0] NB = (BANK_W+1)'(NUM_BANKS);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [BANK_W-1:0] cbank_q, cbank_d;
  logic [ADDR_W-1:0] mem [NUM_BANKS][DEPTH];
  logic [DEPTH-1:0]  valid [NUM_BANKS];
  logic              busy, rd_in, wr_in, clr_in, start, wr_ok, byp, hit;
  logic [BANK_W-1:0] rb, wb;
  assign busy   = state_q == CLEAR;
  assign rd_in  = {1'b0, bus.bank_sel} < NB;
  assign wr_in  = {1'b0, bus.wr_bank} < NB;
  assign clr_in = {1'b0, bus.clr_bank} < NB;
  assign start  = !busy && bus.clr_req && clr_in;
  // out-of-range banks are clamped for indexing; their results are masked by rd_in/wr_in
  assign rb     = rd_in ? bus.bank_sel : '0;
  assign wb     = wr_in ? bus.wr_bank : '0;
  assign wr_ok  = bus.wr_en && wr_in && !(busy && bus.wr_bank == cbank_q);
  assign byp    = wr_ok && bus.wr_bank == bus.bank_sel && bus.wr_idx == bus.rd_idx;
  assign hit    = rd_in && !(busy && bus.bank_sel == cbank_q) && (byp || valid[rb][bus.rd_idx]);
  assign bus.busy = busy;
  always_comb begin
    state_d = busy ? (ptr_q == '1 ? IDLE : CLEAR) : (start ? CLEAR : IDLE);
    ptr_d   = busy ? ptr_q + 1'b1 : '0;
    cbank_d = start ? bus.clr_bank : cbank_q;
  end
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cbank_q      <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_addr  <= '0;
      bus.rd_miss  <= 1'b0;
      bus.wr_rej   <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) valid[b] <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cbank_q      <= cbank_d;
      bus.rd_valid <= bus.rd_en;
      bus.wr_rej   <= bus.wr_en && !wr_ok;
      if (wr_ok) valid[wb][bus.wr_idx] <= 1'b1;
      if (busy) valid[cbank_q][ptr_q] <= 1'b0;
      if (bus.rd_en) begin
        bus.rd_addr <= byp ? bus.wr_addr : (hit ? mem[rb][bus.rd_idx] : '0);
        bus.rd_miss <= !hit;
      end
    end
  end
  always_ff @(posedge CLK) if (wr_ok) mem[wb][bus.wr_idx] <= bus.wr_addr;
endmodule

// File: tb/tb_branch_target_table.sv
// tb_branch_target_table: directed and random stimulus against a table-level reference model
module tb_branch_target_table;
  logic clk = 1'b0;
  logic reset;
  int tests = 0;
  int fails = 0;
  int ref_data [3][16];
  bit ref_valid [3][16];
  int left, sb, n;
  logic [7:0] last_addr;
  logic last_miss;
  bit exp_rv, exp_rej;
  always #5 clk = ~clk;
  branch_target_table_if #(.IDX_W(4), .ADDR_W(8), .BANK_W(2)) bus();
  branch_target_table #(.IDX_W(4), .ADDR_W(8), .NUM_BANKS(3), .BANK_W(2)) dut (
    .CLK(clk), .reset(reset), .bus(bus)
  );
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask
  // Sweep modelled as: whole bank invalid at once, bank locked for 16 cycles
  task automatic tick();
    bit bsy, acc;
    bsy = left > 0;
    acc = bus.wr_en && bus.wr_bank < 3 && !(bsy && bus.wr_bank == sb);
    exp_rej = bus.wr_en && !acc;
    exp_rv = bus.rd_en;
    if (bus.rd_en) begin
      if (bus.bank_sel >= 3 || (bsy && bus.bank_sel == sb)) begin
        last_addr = 0; last_miss = 1;
      end else if (acc && bus.wr_bank == bus.bank_sel && bus.wr_idx == bus.rd_idx) begin
        last_addr = bus.wr_addr; last_miss = 0;
      end else if (ref_valid[bus.bank_sel][bus.rd_idx]) begin
        last_addr = 8'(ref_data[bus.bank_sel][bus.rd_idx]); last_miss = 0;
      end else begin
        last_addr = 0; last_miss = 1;
      end
    end
    if (acc) begin
      ref_data[bus.wr_bank][bus.wr_idx] = bus.wr_addr;
      ref_valid[bus.wr_bank][bus.wr_idx] = 1;
    end
    if (bsy) left--;
    else if (bus.clr_req && bus.clr_bank < 3) begin
      left = 16;
      sb = bus.clr_bank;
      for (int i = 0; i < 16; i++) ref_valid[sb][i] = 0;
    end
    @(posedge clk);
    #1;
    chk("rd_valid", bus.rd_valid, exp_rv);
    chk("rd_addr", bus.rd_addr, last_addr);
    chk("rd_miss", bus.rd_miss, last_miss);
    chk("wr_rej", bus.wr_rej, exp_rej);
    chk("busy", bus.busy, left > 0);
  endtask
  task automatic drv(bit re, int bs, int ri, bit we, int wb, int wi, int wa, bit cr = 0, int cb = 0);
    bus.rd_en = re; bus.bank_sel = 2'(bs); bus.rd_idx = 4'(ri);
    bus.wr_en = we; bus.wr_bank = 2'(wb); bus.wr_idx = 4'(wi); bus.wr_addr = 8'(wa);
    bus.clr_req = cr; bus.clr_bank = 2'(cb);
    tick();
  endtask
  task automatic do_reset();
    bus.rd_en = 0; bus.bank_sel = 0; bus.rd_idx = 0; bus.wr_en = 0; bus.wr_bank = 0;
    bus.wr_idx = 0; bus.wr_addr = 0; bus.clr_req = 0; bus.clr_bank = 0;
    reset = 1;
    #1;
    for (int b = 0; b < 3; b++) for (int i = 0; i < 16; i++) ref_valid[b][i] = 0;
    left = 0; last_addr = 0; last_miss = 0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_rd_miss", bus.rd_miss, 0);
    chk("rst_wr_rej", bus.wr_rej, 0);
    @(posedge clk);
    #2 reset = 0;
  endtask
  initial begin
    do_reset();
    drv(1, 0, 3, 0, 0, 0, 0);
    chk("t1_miss", bus.rd_miss, 1);
    drv(0, 0, 0, 1, 0, 0, 34);
    drv(0, 0, 0, 1, 1, 0, 87);
    drv(1, 0, 0, 0, 0, 0, 0);
    chk("t2_b0", bus.rd_addr, 34);
    drv(1, 1, 0, 0, 0, 0, 0);
    chk("t2_b1", bus.rd_addr, 87);
    drv(1, 2, 5, 1, 2, 5, 165);
    chk("t3_bypass", bus.rd_addr, 165);
    chk("t3_hit", bus.rd_miss, 0);
    for (int i = 0; i < 16; i++) drv(0, 0, 0, 1, 1, i, i * 3 + 1);
    n = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1); n += int'(bus.busy);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0); n += int'(bus.busy);
    drv(1, 1, 2, 0, 0, 0, 0); n += int'(bus.busy);
    chk("t4_swept_miss", bus.rd_miss, 1);
    drv(1, 0, 0, 0, 0, 0, 0); n += int'(bus.busy);
    chk("t4_other_hit", bus.rd_addr, 34);
    drv(0, 0, 0, 1, 1, 4, 99); n += int'(bus.busy);
    chk("t4_wr_rej", bus.wr_rej, 1);
    for (int i = 0; i < 16; i++) begin drv(0, 0, 0, 0, 0, 0, 0); n += int'(bus.busy); end
    chk("t4_busy_len", n, 16);
    for (int i = 0; i < 16; i++) begin
      drv(1, 1, i, 0, 0, 0, 0);
      chk("t4_after_miss", bus.rd_miss, 1);
    end
    drv(0, 0, 0, 1, 3, 2, 55);
    chk("t5_wr_rej", bus.wr_rej, 1);
    drv(1, 3, 2, 0, 0, 0, 0);
    chk("t5_rd_miss", bus.rd_miss, 1);
    drv(0, 0, 0, 1, 2, 7, 200, 1, 2);
    for (int i = 0; i < 17; i++) drv(0, 0, 0, 0, 0, 0, 0);
    drv(1, 2, 7, 0, 0, 0, 0);
    chk("wr_clr_miss", bus.rd_miss, 1);
    for (int i = 1; i < 5; i++) drv(0, 0, 0, 1, 0, i, i + 10);
    drv(0, 0, 0, 1, 2, 0, 77);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) drv(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drv(1, 0, i, 0, 0, 0, 0);
      chk("t6_b0_miss", bus.rd_miss, 1);
    end
    drv(1, 2, 0, 0, 0, 0, 0);
    chk("t6_b2_miss", bus.rd_miss, 1);
    drv(1, 2, 5, 0, 0, 0, 0);
    chk("t6_b2i5_miss", bus.rd_miss, 1);
    for (int i = 0; i < 400; i++)
      drv($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 15),
          $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 15),
          $urandom_range(0, 255), $urandom_range(0, 19) == 0, $urandom_range(0, 3));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
